// File: rtl/mem_axi_bridge_pkg.sv
// mem_axi_bridge_pkg
// Shared definitions for the memory-stage to AXI4-Lite bridge: bus widths,
// FSM state encoding, access size codes, AXI response codes and the
// alignment rule that decides whether a request may go out on AXI at all.
package mem_axi_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A request is aligned when it does not straddle its natural boundary
    // inside the 8-byte data beat.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = (off[0] == 1'b0);
            SIZE_WORD: ok = (off[1:0] == 2'b00);
            default:   ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_axi_bridge_lane.sv
// mem_axi_lane
// Purely combinational byte-lane logic for the bridge.
//   Write side: w_off/w_size/w_data -> w_strb (byte strobes) and w_lanes
//               (store data moved onto its byte lanes).
//   Read side:  r_off/r_size/r_data -> r_value (beat shifted down to bit 0
//               and zero-extended from the access size).
module mem_axi_lane
    import mem_axi_bridge_pkg::*;
(
    input  logic [2:0]        w_off,
    input  logic [1:0]        w_size,
    input  logic [DATA_W-1:0] w_data,
    output logic [STRB_W-1:0] w_strb,
    output logic [DATA_W-1:0] w_lanes,
    input  logic [2:0]        r_off,
    input  logic [1:0]        r_size,
    input  logic [DATA_W-1:0] r_data,
    output logic [DATA_W-1:0] r_value
);

    logic [DATA_W-1:0] r_shifted;

    always_comb begin
        w_strb = 8'hFF;
        case (w_size)
            SIZE_BYTE: w_strb = 8'h01 << w_off;
            SIZE_HALF: w_strb = 8'h03 << w_off;
            SIZE_WORD: w_strb = 8'h0F << w_off;
            default:   w_strb = 8'hFF;
        endcase
        w_lanes = w_data << {w_off, 3'b000};
    end

    always_comb begin
        r_shifted = r_data >> {r_off, 3'b000};
        r_value   = r_shifted;
        case (r_size)
            SIZE_BYTE: r_value = {56'd0, r_shifted[7:0]};
            SIZE_HALF: r_value = {48'd0, r_shifted[15:0]};
            SIZE_WORD: r_value = {32'd0, r_shifted[31:0]};
            default:   r_value = r_shifted;
        endcase
    end

endmodule

// File: rtl/mem_axi_bridge.sv
// mem_axi_bridge
// Turns one memory-stage request (read or write, byte..dword) into a single
// AXI4-Lite transaction and returns a one-cycle ready_o pulse with the
// response and, for reads, the zero-extended load data.
//   clk, rst (async, active-low)
//   mem_axi_bridge_valid/req/addr/size/data_write_i : request in
//   mem_axi_bridge_ready/data_read/resp_o           : completion out
//   mem_axi_bridge_aw*/w*/b*/ar*/r*                 : AXI4-Lite master
//   dbg_state_o                                     : current FSM state
// Handshake rule on every AXI channel: a transfer happens on a rising edge
// where valid and ready are both high; a valid, once raised, is held until
// that edge. All valid/ready outputs come straight from flops.
module mem_axi_bridge
    import mem_axi_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_axi_bridge_valid_i,
    input  logic              mem_axi_bridge_req_i,
    input  logic [ADDR_W-1:0] mem_axi_bridge_addr_i,
    input  logic [1:0]        mem_axi_bridge_size_i,
    input  logic [DATA_W-1:0] mem_axi_bridge_data_write_i,
    output logic              mem_axi_bridge_ready_o,
    output logic [DATA_W-1:0] mem_axi_bridge_data_read_o,
    output logic [1:0]        mem_axi_bridge_resp_o,
    output logic              mem_axi_bridge_awvalid_o,
    input  logic              mem_axi_bridge_awready_i,
    output logic [31:0]       mem_axi_bridge_awaddr_o,
    output logic              mem_axi_bridge_wvalid_o,
    input  logic              mem_axi_bridge_wready_i,
    output logic [DATA_W-1:0] mem_axi_bridge_wdata_o,
    output logic [STRB_W-1:0] mem_axi_bridge_wstrb_o,
    input  logic              mem_axi_bridge_bvalid_i,
    output logic              mem_axi_bridge_bready_o,
    input  logic [1:0]        mem_axi_bridge_bresp_i,
    output logic              mem_axi_bridge_arvalid_o,
    input  logic              mem_axi_bridge_arready_i,
    output logic [31:0]       mem_axi_bridge_araddr_o,
    input  logic              mem_axi_bridge_rvalid_i,
    output logic              mem_axi_bridge_rready_o,
    input  logic [DATA_W-1:0] mem_axi_bridge_rdata_i,
    input  logic [1:0]        mem_axi_bridge_rresp_i,
    output logic [2:0]        dbg_state_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              ready_q, ready_d;

    logic [STRB_W-1:0] lane_strb;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rvalue;
    logic              aw_done, w_done;

    // Write lanes are computed from the live request so they can be latched
    // in IDLE; read extraction uses the latched offset and size.
    mem_axi_lane u_lane (
        .w_off   (mem_axi_bridge_addr_i[2:0]),
        .w_size  (mem_axi_bridge_size_i),
        .w_data  (mem_axi_bridge_data_write_i),
        .w_strb  (lane_strb),
        .w_lanes (lane_wdata),
        .r_off   (addr_q[2:0]),
        .r_size  (size_q),
        .r_data  (mem_axi_bridge_rdata_i),
        .r_value (lane_rvalue)
    );

    // A channel counts as done once its valid has dropped or is being
    // accepted this cycle; AW and W may finish in either order.
    assign aw_done = !awvalid_q || mem_axi_bridge_awready_i;
    assign w_done  = !wvalid_q  || mem_axi_bridge_wready_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        ready_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_axi_bridge_valid_i) begin
                    addr_d  = mem_axi_bridge_addr_i;
                    size_d  = mem_axi_bridge_size_i;
                    wdata_d = lane_wdata;
                    wstrb_d = lane_strb;
                    if (!is_aligned(mem_axi_bridge_size_i, mem_axi_bridge_addr_i[2:0])) begin
                        resp_d  = RESP_SLVERR;
                        ready_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (mem_axi_bridge_req_i) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                awvalid_d = awvalid_q && !mem_axi_bridge_awready_i;
                wvalid_d  = wvalid_q  && !mem_axi_bridge_wready_i;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (mem_axi_bridge_bvalid_i) begin
                    resp_d  = mem_axi_bridge_bresp_i;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    bready_d = 1'b1;
                end
            end
            ST_READ: begin
                if (mem_axi_bridge_arready_i) begin
                    rready_d = 1'b1;
                    state_d  = ST_RDATA;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            ST_RDATA: begin
                if (mem_axi_bridge_rvalid_i) begin
                    rdata_d = lane_rvalue;
                    resp_d  = mem_axi_bridge_rresp_i;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    rready_d = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ready_q   <= ready_d;
        end
    end

    assign mem_axi_bridge_ready_o     = ready_q;
    assign mem_axi_bridge_data_read_o = rdata_q;
    assign mem_axi_bridge_resp_o      = resp_q;
    assign mem_axi_bridge_awvalid_o   = awvalid_q;
    assign mem_axi_bridge_awaddr_o    = addr_q[31:0];
    assign mem_axi_bridge_wvalid_o    = wvalid_q;
    assign mem_axi_bridge_wdata_o     = wdata_q;
    assign mem_axi_bridge_wstrb_o     = wstrb_q;
    assign mem_axi_bridge_bready_o    = bready_q;
    assign mem_axi_bridge_arvalid_o   = arvalid_q;
    assign mem_axi_bridge_araddr_o    = addr_q[31:0];
    assign mem_axi_bridge_rready_o    = rready_q;
    assign dbg_state_o                = state_q;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// tb_mem_axi_bridge
// Directed bench for mem_axi_bridge: a small AXI4-Lite slave with a
// programmable AW delay, a request driver task and one checking task.
module tb_mem_axi_bridge;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        valid_i = 1'b0, req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [1:0]  size_i = '0;
    logic [63:0] data_i = '0;
    logic        ready_o;
    logic [63:0] data_read_o;
    logic [1:0]  resp_o;
    logic        awvalid_o, awready_i, wvalid_o, wready_i;
    logic [31:0] awaddr_o, araddr_o;
    logic [63:0] wdata_o;
    logic [7:0]  wstrb_o;
    logic        bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;
    logic [1:0]  bresp_i, rresp_i;
    logic [63:0] rdata_i;
    logic [2:0]  dbg_state_o;

    mem_axi_bridge dut (
        .clk                         (clk),
        .rst                         (rst),
        .mem_axi_bridge_valid_i      (valid_i),
        .mem_axi_bridge_req_i        (req_i),
        .mem_axi_bridge_addr_i       (addr_i),
        .mem_axi_bridge_size_i       (size_i),
        .mem_axi_bridge_data_write_i (data_i),
        .mem_axi_bridge_ready_o      (ready_o),
        .mem_axi_bridge_data_read_o  (data_read_o),
        .mem_axi_bridge_resp_o       (resp_o),
        .mem_axi_bridge_awvalid_o    (awvalid_o),
        .mem_axi_bridge_awready_i    (awready_i),
        .mem_axi_bridge_awaddr_o     (awaddr_o),
        .mem_axi_bridge_wvalid_o     (wvalid_o),
        .mem_axi_bridge_wready_i     (wready_i),
        .mem_axi_bridge_wdata_o      (wdata_o),
        .mem_axi_bridge_wstrb_o      (wstrb_o),
        .mem_axi_bridge_bvalid_i     (bvalid_i),
        .mem_axi_bridge_bready_o     (bready_o),
        .mem_axi_bridge_bresp_i      (bresp_i),
        .mem_axi_bridge_arvalid_o    (arvalid_o),
        .mem_axi_bridge_arready_i    (arready_i),
        .mem_axi_bridge_araddr_o     (araddr_o),
        .mem_axi_bridge_rvalid_i     (rvalid_i),
        .mem_axi_bridge_rready_o     (rready_o),
        .mem_axi_bridge_rdata_i      (rdata_i),
        .mem_axi_bridge_rresp_i      (rresp_i),
        .dbg_state_o                 (dbg_state_o)
    );

    // ---------------- slave model ----------------
    int   aw_delay = 0;
    int   aw_cnt   = 0;
    logic wready_r = 1'b1, bvalid_r = 1'b1, arready_r = 1'b1, rvalid_r = 1'b1;
    logic [1:0]  bresp_r = 2'b00, rresp_r = 2'b00;
    logic [63:0] rdata_r = '0;

    assign awready_i = awvalid_o && (aw_cnt >= aw_delay);
    assign wready_i  = wready_r;
    assign bvalid_i  = bvalid_r;
    assign bresp_i   = bresp_r;
    assign arready_i = arready_r;
    assign rvalid_i  = rvalid_r;
    assign rresp_i   = rresp_r;
    assign rdata_i   = rdata_r;

    always @(posedge clk) begin
        if (awvalid_o && !awready_i) aw_cnt <= aw_cnt + 1;
        else                         aw_cnt <= 0;
    end

    // ---------------- scoreboard / checker ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Observations gathered while a request is in flight.
    int          w_cycles;
    logic [7:0]  seen_wstrb;
    logic [63:0] seen_wdata;
    logic [31:0] seen_awaddr;
    logic        seen_ar;
    logic        bready_early;

    // ---------------- driver ----------------
    // Issues one request and returns the cycle (counted from the cycle
    // valid_i is first sampled) in which ready_o was seen, or -1 on timeout.
    task automatic run_req(input logic req, input logic [31:0] addr, input logic [1:0] size,
                           input logic [63:0] data, input bit scramble, output int lat);
        @(negedge clk);
        valid_i = 1'b1; req_i = req; addr_i = addr; size_i = size; data_i = data;
        lat = -1; w_cycles = 0; seen_wstrb = '0; seen_wdata = '0; seen_awaddr = '0;
        seen_ar = 1'b0; bready_early = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (wvalid_o) begin
                w_cycles++;
                seen_wstrb = wstrb_o;
                seen_wdata = wdata_o;
            end
            if (awvalid_o) seen_awaddr = awaddr_o;
            if (arvalid_o) seen_ar = 1'b1;
            if (bready_o && awvalid_o) bready_early = 1'b1;
            if (scramble) begin
                addr_i = $urandom;
                size_i = 2'($urandom_range(0, 3));
                data_i = {$urandom, $urandom};
                req_i  = ~req;
            end
            if (ready_o) begin
                lat = c;
                break;
            end
        end
        valid_i = 1'b0;
        @(negedge clk);
        check("ready_pulse", 64'(ready_o), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    int lat;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready",   64'(ready_o),   64'd0);
        check("rst_awvalid", 64'(awvalid_o), 64'd0);
        check("rst_wvalid",  64'(wvalid_o),  64'd0);
        check("rst_arvalid", 64'(arvalid_o), 64'd0);
        check("rst_rready",  64'(rready_o),  64'd0);
        check("rst_bready",  64'(bready_o),  64'd0);
        check("rst_rdata",   data_read_o,    64'd0);
        check("rst_resp",    64'(resp_o),    64'd0);
        check("rst_wstrb",   64'(wstrb_o),   64'd0);
        check("rst_state",   64'(dbg_state_o), 64'd0);
        rst = 1'b1;

        // Dword read, zero-wait slave
        rdata_r = 64'h1122334455667788; rresp_r = 2'b00;
        run_req(1'b0, 32'h8000_0000, 2'b11, 64'd0, 1'b0, lat);
        check("dw_rd_lat",  64'(lat), 64'd3);
        check("dw_rd_data", data_read_o, 64'h1122334455667788);
        check("dw_rd_resp", 64'(resp_o), 64'd0);

        // Half read at offset 6, inputs scrambled after latching
        run_req(1'b0, 32'h8000_0006, 2'b01, 64'd0, 1'b1, lat);
        check("hw_rd_lat",  64'(lat), 64'd3);
        check("hw_rd_data", data_read_o, 64'h0000_0000_0000_1122);

        // Misaligned word read: no AXI traffic, SLVERR next cycle
        run_req(1'b0, 32'h8000_0002, 2'b10, 64'd0, 1'b0, lat);
        check("mis_lat",  64'(lat), 64'd1);
        check("mis_ar",   64'(seen_ar), 64'd0);
        check("mis_resp", 64'(resp_o), 64'd2);
        check("mis_data", data_read_o, 64'h1122);

        // Byte read at offset 5 with DECERR
        rresp_r = 2'b11;
        run_req(1'b0, 32'h8000_0005, 2'b00, 64'd0, 1'b0, lat);
        check("b_rd_data", data_read_o, 64'h33);
        check("b_rd_resp", 64'(resp_o), 64'd3);
        rresp_r = 2'b00;

        // Byte write at offset 3
        bresp_r = 2'b00;
        run_req(1'b1, 32'h8000_0003, 2'b00, 64'hAB, 1'b0, lat);
        check("b_wr_lat",    64'(lat), 64'd3);
        check("b_wr_strb",   64'(seen_wstrb), 64'h08);
        check("b_wr_data",   seen_wdata, 64'h0000_0000_AB00_0000);
        check("b_wr_awaddr", 64'(seen_awaddr), 64'h8000_0003);
        check("b_wr_resp",   64'(resp_o), 64'd0);
        check("b_wr_rdkeep", data_read_o, 64'h33);

        // Half write at offset 2
        run_req(1'b1, 32'h8000_0002, 2'b01, 64'hBEEF, 1'b0, lat);
        check("h_wr_strb", 64'(seen_wstrb), 64'h0C);
        check("h_wr_data", seen_wdata, 64'h0000_0000_BEEF_0000);

        // Write: wready immediate, awready two cycles late, SLVERR
        aw_delay = 2; bresp_r = 2'b10;
        run_req(1'b1, 32'h8000_0010, 2'b11, 64'h0102030405060708, 1'b0, lat);
        check("late_aw_lat",    64'(lat), 64'd5);
        check("late_aw_wcyc",   64'(w_cycles), 64'd1);
        check("late_aw_bready", 64'(bready_early), 64'd0);
        check("late_aw_strb",   64'(seen_wstrb), 64'hFF);
        check("late_aw_resp",   64'(resp_o), 64'd2);
        aw_delay = 0; bresp_r = 2'b00;

        // Reset while waiting in RDATA
        rvalid_r = 1'b0;
        @(negedge clk);
        valid_i = 1'b1; req_i = 1'b0; addr_i = 32'h8000_0008; size_i = 2'b11;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (rready_o) begin
                lat = c;
                break;
            end
        end
        check("rst_rdata_reached", 64'(lat), 64'd2);
        valid_i = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_rready", 64'(rready_o), 64'd0);
        check("arst_ready",  64'(ready_o),  64'd0);
        check("arst_state",  64'(dbg_state_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        rvalid_r = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 64'({arvalid_o, rready_o, ready_o, dbg_state_o}), 64'd0);

        rdata_r = 64'hCAFE_F00D_1234_5678;
        run_req(1'b0, 32'h8000_0010, 2'b10, 64'd0, 1'b0, lat);
        check("post_rst_lat",  64'(lat), 64'd3);
        check("post_rst_data", data_read_o, 64'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
